// File: rtl/simd_alu_pipe.sv
// rtl/simd_alu_pipe.sv - two-stage multi-lane SIMD ALU with saturating, fixed-point multiply and MACC ops
module simd_alu_pipe #(
    parameter int NUM_LANES     = 4,
    parameter int BIT_WIDTH     = 32,
    parameter int FUNCTION_BITS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [FUNCTION_BITS-1:0]       fn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*BIT_WIDTH-1:0] data_in0,
    input  logic [NUM_LANES*BIT_WIDTH-1:0] data_in1,
    input  logic [NUM_LANES*BIT_WIDTH-1:0] data_acc,
    input  logic [7:0]                     dest_integer_bits,
    input  logic [7:0]                     src1_integer_bits,
    input  logic [7:0]                     src2_integer_bits,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*BIT_WIDTH-1:0] data_out,
    output logic [NUM_LANES-1:0]           sat_flag
);
    localparam int W   = BIT_WIDTH;
    localparam int LW  = NUM_LANES * BIT_WIDTH;
    localparam int PW  = 2 * BIT_WIDTH;
    localparam int XW  = 3 * BIT_WIDTH;
    localparam int SHW = 12;
    localparam int SAW = $clog2(BIT_WIDTH);

    localparam logic [FUNCTION_BITS-1:0] OP_ADD  = FUNCTION_BITS'(0);
    localparam logic [FUNCTION_BITS-1:0] OP_SUB  = FUNCTION_BITS'(1);
    localparam logic [FUNCTION_BITS-1:0] OP_MUL  = FUNCTION_BITS'(2);
    localparam logic [FUNCTION_BITS-1:0] OP_MACC = FUNCTION_BITS'(3);
    localparam logic [FUNCTION_BITS-1:0] OP_MAX  = FUNCTION_BITS'(5);
    localparam logic [FUNCTION_BITS-1:0] OP_MIN  = FUNCTION_BITS'(6);
    localparam logic [FUNCTION_BITS-1:0] OP_SHR  = FUNCTION_BITS'(7);
    localparam logic [FUNCTION_BITS-1:0] OP_SHL  = FUNCTION_BITS'(8);
    localparam logic [FUNCTION_BITS-1:0] OP_NOT  = FUNCTION_BITS'(12);
    localparam logic [FUNCTION_BITS-1:0] OP_AND  = FUNCTION_BITS'(13);
    localparam logic [FUNCTION_BITS-1:0] OP_OR   = FUNCTION_BITS'(14);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SHW-1:0] SH_LO = SHW'(-(W - 1));
    localparam logic signed [SHW-1:0] SH_HI = SHW'(2 * W - 1);

    // Returns {saturated, value} of x+y or x-y clamped to the signed lane range.
    function automatic logic [W:0] sat_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sub);
        logic [W:0] s;
        logic [W:0] r;
        s = sub ? ({x[W-1], x} - {y[W-1], y}) : ({x[W-1], x} + {y[W-1], y});
        if (s[W] != s[W-1]) r = {1'b1, (s[W] ? SAT_MIN : SAT_MAX)};
        else                r = {1'b0, s[W-1:0]};
        return r;
    endfunction

    // Realigns the full product to the destination format; a left shift can grow
    // past 2W bits, so the work is done in a 3W container before range checking.
    function automatic logic [W:0] fx_scale(input logic [PW-1:0] prod,
                                            input logic signed [SHW-1:0] sh);
        logic signed [XW-1:0] ext;
        logic signed [XW-1:0] scaled;
        logic [W:0]           r;
        ext = {{W{prod[PW-1]}}, prod};
        if (sh < 0) scaled = ext << (-sh);
        else        scaled = ext >>> sh;
        if ((&scaled[XW-1:W-1]) || !(|scaled[XW-1:W-1])) r = {1'b0, scaled[W-1:0]};
        else r = {1'b1, (scaled[XW-1] ? SAT_MIN : SAT_MAX)};
        return r;
    endfunction

    function automatic logic [W:0] lane_op(input logic [FUNCTION_BITS-1:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] acc, input logic [PW-1:0] prod,
                                           input logic signed [SHW-1:0] sh);
        logic [W:0] r;
        logic [W:0] fx;
        logic [W:0] mac;
        fx  = fx_scale(prod, sh);
        mac = sat_sum(acc, fx[W-1:0], 1'b0);
        r   = {1'b0, a};
        case (op)
            OP_ADD:  r = sat_sum(a, b, 1'b0);
            OP_SUB:  r = sat_sum(a, b, 1'b1);
            OP_MUL:  r = fx;
            OP_MACC: r = {fx[W] | mac[W], mac[W-1:0]};
            OP_MAX:  r = {1'b0, (($signed(a) > $signed(b)) ? a : b)};
            OP_MIN:  r = {1'b0, (($signed(a) < $signed(b)) ? a : b)};
            OP_SHR:  r = {1'b0, ($signed(a) >>> b[SAW-1:0])};
            OP_SHL:  r = {1'b0, (a << b[SAW-1:0])};
            OP_NOT:  r = {1'b0, ~a};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    logic                    stall;
    logic                    accept;
    logic signed [SHW-1:0]   sh_raw;
    logic signed [SHW-1:0]   sh_d;
    logic [NUM_LANES*PW-1:0] prod_d;

    logic                     s1_valid;
    logic [FUNCTION_BITS-1:0] s1_fn;
    logic [LW-1:0]            s1_a;
    logic [LW-1:0]            s1_b;
    logic [LW-1:0]            s1_acc;
    logic signed [SHW-1:0]    s1_sh;
    logic [NUM_LANES*PW-1:0]  s1_prod;

    logic [NUM_LANES*(W+1)-1:0] lane_r;
    logic [LW-1:0]              data_d;
    logic [NUM_LANES-1:0]       sat_d;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // frac1 + frac2 - fracd collapses to W - int1 - int2 + intd.
    always_comb begin
        sh_raw = SHW'(W) - {4'b0, src1_integer_bits} - {4'b0, src2_integer_bits}
                 + {4'b0, dest_integer_bits};
        if (sh_raw < SH_LO)      sh_d = SH_LO;
        else if (sh_raw > SH_HI) sh_d = SH_HI;
        else                     sh_d = sh_raw;
        prod_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            prod_d[i*PW +: PW] = PW'($signed(data_in0[i*W +: W])) * PW'($signed(data_in1[i*W +: W]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_fn    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_acc   <= '0;
            s1_sh    <= '0;
            s1_prod  <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_fn   <= fn;
                s1_a    <= data_in0;
                s1_b    <= data_in1;
                s1_acc  <= data_acc;
                s1_sh   <= sh_d;
                s1_prod <= prod_d;
            end
        end
    end

    always_comb begin
        lane_r = '0;
        data_d = '0;
        sat_d  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_r[i*(W+1) +: W+1] = lane_op(s1_fn, s1_a[i*W +: W], s1_b[i*W +: W],
                                             s1_acc[i*W +: W], s1_prod[i*PW +: PW], s1_sh);
            data_d[i*W +: W] = lane_r[i*(W+1) +: W];
            sat_d[i]         = lane_r[i*(W+1) + W];
        end
    end

    // S2 doubles as the output register; it only moves when downstream is not stalling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sat_flag  <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= data_d;
                sat_flag <= sat_d;
            end
        end
    end
endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb/tb_simd_alu_pipe.sv - directed and randomized self-checking bench for simd_alu_pipe
module tb_simd_alu_pipe;
    localparam int NL = 4;
    localparam int LW = 128;

    typedef struct packed {
        logic [LW-1:0] d;
        logic [NL-1:0] s;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    fn;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] data_in0;
    logic [LW-1:0] data_in1;
    logic [LW-1:0] data_acc;
    logic [7:0]    dest_integer_bits;
    logic [7:0]    src1_integer_bits;
    logic [7:0]    src2_integer_bits;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] data_out;
    logic [NL-1:0] sat_flag;

    int checks = 0;
    int passed = 0;

    simd_alu_pipe #(.NUM_LANES(4), .BIT_WIDTH(32), .FUNCTION_BITS(4)) dut (
        .clk(clk), .reset(reset), .fn(fn), .in_valid(in_valid), .in_ready(in_ready),
        .data_in0(data_in0), .data_in1(data_in1), .data_acc(data_acc),
        .dest_integer_bits(dest_integer_bits), .src1_integer_bits(src1_integer_bits),
        .src2_integer_bits(src2_integer_bits), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passed, checks);
        $fatal(1);
    end

    // Reference model: exact wide arithmetic, numeric clamping to the 32-bit range.
    function automatic logic [32:0] clip(input logic signed [127:0] v);
        if (v > 128'sh7FFFFFFF) return {1'b1, 32'h7FFFFFFF};
        if (v < -128'sh80000000) return {1'b1, 32'h80000000};
        return {1'b0, v[31:0]};
    endfunction

    function automatic logic [32:0] ref_lane(input int op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] acc, input int di, input int i1, input int i2);
        longint av, bv, cv;
        logic signed [127:0] p;
        logic signed [31:0] as;
        logic [32:0] f, m;
        int sh;
        av = longint'($signed(a));
        bv = longint'($signed(b));
        cv = longint'($signed(acc));
        as = a;
        sh = (32 - i1) + (32 - i2) - (32 - di);
        if (sh < -31) sh = -31;
        if (sh > 63) sh = 63;
        p = av * bv;
        if (sh >= 0) p = p >>> sh;
        else p = p <<< (-sh);
        f = clip(p);
        case (op)
            0: return clip(av + bv);
            1: return clip(av - bv);
            2: return f;
            3: begin
                m = clip(cv + longint'($signed(f[31:0])));
                return {f[32] | m[32], m[31:0]};
            end
            5: return {1'b0, ((av > bv) ? a : b)};
            6: return {1'b0, ((av < bv) ? a : b)};
            7: return {1'b0, (as >>> b[4:0])};
            8: return {1'b0, (a << b[4:0])};
            12: return {1'b0, ~a};
            13: return {1'b0, a & b};
            14: return {1'b0, a | b};
            default: return {1'b0, a};
        endcase
    endfunction

    function automatic beat_t ref_beat(input int op, input logic [LW-1:0] a, input logic [LW-1:0] b,
                                       input logic [LW-1:0] acc, input int di, input int i1, input int i2);
        beat_t r;
        logic [32:0] l;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            l = ref_lane(op, a[i*32 +: 32], b[i*32 +: 32], acc[i*32 +: 32], di, i1, i2);
            r.d[i*32 +: 32] = l[31:0];
            r.s[i] = l[32];
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'($urandom_range(0, 40)) - 32'd20;
            3: return 32'($urandom_range(0, 32'h3FFFF));
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [7:0] rnd_ib();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
        return 8'($urandom_range(8, 32));
    endfunction

    task automatic randomize_beat(input bit add_only);
        fn = add_only ? 4'd0 : 4'($urandom_range(0, 15));
        for (int i = 0; i < NL; i++) begin
            data_in0[i*32 +: 32] = rnd_word();
            data_in1[i*32 +: 32] = rnd_word();
            data_acc[i*32 +: 32] = rnd_word();
        end
        dest_integer_bits = rnd_ib();
        src1_integer_bits = rnd_ib();
        src2_integer_bits = rnd_ib();
    endtask

    // Drives one beat into an idle pipe; reports out_valid one and two edges after accept.
    task automatic run_one(input logic [3:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b,
                           input logic [LW-1:0] acc, input logic [7:0] ib,
                           output logic ov1, output logic ov2, output logic [LW-1:0] d, output logic [NL-1:0] s);
        @(negedge clk);
        fn = op; data_in0 = a; data_in1 = b; data_acc = acc;
        dest_integer_bits = ib; src1_integer_bits = ib; src2_integer_bits = ib;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 ov1 = out_valid;
        @(negedge clk);
        #1 ov2 = out_valid; d = data_out; s = sat_flag;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fn = 4'd0;
        data_in0 = '0; data_in1 = '0; data_acc = '0;
        dest_integer_bits = 8'd16; src1_integer_bits = 8'd16; src2_integer_bits = 8'd16;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (data_out !== '0) $display("FAIL reset_data_out: got %h want 0", data_out); else passed++;
        checks++; if (sat_flag !== '0) $display("FAIL reset_sat_flag: got %b want 0", sat_flag); else passed++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_add();
        logic ov1, ov2; logic [LW-1:0] d; logic [NL-1:0] s;
        run_one(4'd0, {32'h80000000, 32'hFFFFFFFB, 32'h7FFFFFFF, 32'h00000001},
                {32'hFFFFFFFF, 32'h00000003, 32'h00000001, 32'h00000002}, '0, 8'd16, ov1, ov2, d, s);
        checks++; if (ov1 !== 1'b0 || ov2 !== 1'b1) $display("FAIL add_latency: out_valid edge1=%b edge2=%b want 0 1", ov1, ov2); else passed++;
        checks++; if (d !== {32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000003}) $display("FAIL add_data: got %h", d); else passed++;
        checks++; if (s !== 4'b1010) $display("FAIL add_sat: got %b want 1010", s); else passed++;
    endtask

    task automatic test_mul();
        logic ov1, ov2; logic [LW-1:0] d; logic [NL-1:0] s;
        run_one(4'd2, {32'h0, 32'h0, 32'h01000000, 32'h00018000},
                {32'h0, 32'h0, 32'h01000000, 32'h00020000}, '0, 8'd16, ov1, ov2, d, s);
        checks++; if (d !== {32'h0, 32'h0, 32'h7FFFFFFF, 32'h00030000}) $display("FAIL mul_data: got %h", d); else passed++;
        checks++; if (s !== 4'b0010) $display("FAIL mul_sat: got %b want 0010", s); else passed++;
    endtask

    task automatic test_macc();
        logic ov1, ov2; logic [LW-1:0] d; logic [NL-1:0] s;
        run_one(4'd3, {32'h0, 32'h00010000, 32'h00010000, 32'h00008000},
                {32'h0, 32'hFFFF0000, 32'h00010000, 32'h00008000},
                {32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h00010000}, 8'd16, ov1, ov2, d, s);
        checks++; if (d !== {32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h00014000}) $display("FAIL macc_data: got %h", d); else passed++;
        checks++; if (s !== 4'b0110) $display("FAIL macc_sat: got %b want 0110", s); else passed++;
    endtask

    task automatic test_minmax_shift();
        logic ov1, ov2; logic [LW-1:0] d; logic [NL-1:0] s;
        logic [3:0] ops[4];
        logic [LW-1:0] want[4];
        ops  = '{4'd5, 4'd6, 4'd7, 4'd8};
        want = '{{32'h7FFFFFFF, 32'h00000005, 32'h00000020, 32'h00000003},
                 {32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF8, 32'hFFFFFFF8},
                 {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF},
                 {32'h00000000, 32'h0A000000, 32'hFFFFFFF8, 32'hFFFFFFC0}};
        for (int k = 0; k < 4; k++) begin
            run_one(ops[k], {32'h80000000, 32'h00000005, 32'hFFFFFFF8, 32'hFFFFFFF8},
                    {32'h7FFFFFFF, 32'hFFFFFFF9, 32'h00000020, 32'h00000003}, '0, 8'd16, ov1, ov2, d, s);
            checks++;
            if (d !== want[k] || s !== 4'b0000)
                $display("FAIL minmax_shift op%0d: got %h sat %b want %h sat 0000", ops[k], d, s, want[k]);
            else passed++;
        end
    endtask

    task automatic test_stream(input string name, input int n, input bit bp);
        beat_t q[$];
        beat_t e;
        int sent, got, cyc, extra;
        bit have, stalled;
        logic [LW-1:0] pd;
        logic [NL-1:0] ps;
        sent = 0; got = 0; cyc = 0; extra = 0; have = 0; stalled = 0; pd = '0; ps = '0;
        while (got < n && cyc < 40 * n + 100) begin
            @(negedge clk);
            if (!have && sent < n && (bp || $urandom_range(0, 3) != 0)) begin
                randomize_beat(bp);
                have = 1;
            end
            in_valid = have;
            out_ready = bp ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 3) != 0);
            #1;
            if (stalled) begin
                checks++;
                if (data_out !== pd || sat_flag !== ps)
                    $display("FAIL %s hold cyc %0d: got %h/%b want %h/%b", name, cyc, data_out, sat_flag, pd, ps);
                else passed++;
            end
            if (bp && cyc >= 3 && cyc <= 5) begin
                checks++;
                if (in_ready !== 1'b0) $display("FAIL %s in_ready cyc %0d: got %b want 0", name, cyc, in_ready);
                else passed++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) $display("FAIL %s unexpected beat: got %h want none", name, data_out);
                else begin
                    e = q.pop_front();
                    if (data_out !== e.d || sat_flag !== e.s)
                        $display("FAIL %s beat %0d: got %h/%b want %h/%b", name, got, data_out, sat_flag, e.d, e.s);
                    else passed++;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_beat(int'(fn), data_in0, data_in1, data_acc, int'(dest_integer_bits),
                                     int'(src1_integer_bits), int'(src2_integer_bits)));
                sent++;
                have = 0;
            end
            stalled = out_valid && !out_ready;
            pd = data_out;
            ps = sat_flag;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != n || q.size() != 0) $display("FAIL %s count: got %0d beats, %0d pending, want %0d", name, got, q.size(), n);
        else passed++;
        repeat (4) begin
            @(negedge clk);
            #1 if (out_valid) extra++;
        end
        checks++; if (extra != 0) $display("FAIL %s duplicate: got %0d extra beats want 0", name, extra); else passed++;
    endtask

    task automatic test_backpressure();
        test_stream("backpressure", 6, 1'b1);
    endtask

    task automatic test_random();
        test_stream("random", 400, 1'b0);
    endtask

    task automatic test_reset_midflight();
        logic ov1, ov2; logic [LW-1:0] d; logic [NL-1:0] s;
        int stale;
        stale = 0;
        @(negedge clk);
        fn = 4'd0; data_in0 = {4{32'd100}}; data_in1 = {4{32'd1}}; data_acc = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        data_in0 = {4{32'd200}};
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL midflight_reset_valid: got %b want 0", out_valid); else passed++;
        checks++; if (data_out !== '0) $display("FAIL midflight_reset_data: got %h want 0", data_out); else passed++;
        @(negedge clk);
        reset = 1'b1;
        run_one(4'd0, {32'd7, 32'd6, 32'd5, 32'd4}, {4{32'd5}}, '0, 8'd16, ov1, ov2, d, s);
        checks++; if (ov1 !== 1'b0 || ov2 !== 1'b1) $display("FAIL midflight_latency: edge1=%b edge2=%b want 0 1", ov1, ov2); else passed++;
        checks++; if (d !== {32'd12, 32'd11, 32'd10, 32'd9} || s !== 4'b0000) $display("FAIL midflight_data: got %h/%b", d, s); else passed++;
        repeat (4) begin
            @(negedge clk);
            #1 if (out_valid) stale++;
        end
        checks++; if (stale != 0) $display("FAIL midflight_stale: got %0d stale beats want 0", stale); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_macc();
        test_minmax_shift();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
